// File: rtl/givens_pkg.sv
// givens_pkg: shared widths, row/element types, reader states and element extraction
package givens_pkg;
    localparam int N      = 4;
    localparam int ELEM_W = 8;
    localparam int ROW_W  = 32;
    typedef logic [ROW_W-1:0] row_t;
    typedef logic [ELEM_W-1:0] elem_t;
    typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_PRESENT, S_DONE} state_e;
    function automatic elem_t get_elem(row_t r, logic [1:0] idx);
        return r[ROW_W-1-ELEM_W*idx -: ELEM_W];
    endfunction
endpackage

// File: rtl/givens_rd_latency_pipe.sv
// givens_rd_latency_pipe: flags the cycle in which BRAM port-B data is valid after an enable
module givens_rd_latency_pipe #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    output logic valid_o
);
    logic [DEPTH-1:0] sr_q;
    always_ff @(posedge clk) begin
        if (rst) sr_q <= '0;
        else sr_q <= DEPTH'({sr_q, en_i});
    end
    assign valid_o = sr_q[DEPTH-1];
endmodule

// File: rtl/givens_matrix_reader.sv
// givens_matrix_reader: reads the 4x4 Givens matrix from BRAM port B and streams rows over valid/ready.
// Define GIVENS_TRANSPOSE_EN to add the transpose port, row buffer and column emit phase.
module givens_matrix_reader
    import givens_pkg::*;
#(
    parameter int READ_LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_read_givens,
`ifdef GIVENS_TRANSPOSE_EN
    input  logic             transpose,
`endif
    output logic             enb_givens,
    output logic [1:0]       addrb_givens,
    input  logic [ROW_W-1:0] doutb_givens,
    output logic [ROW_W-1:0] vec_data,
    output logic [1:0]       vec_idx,
    output logic             vec_valid,
    input  logic             vec_ready,
    output logic             busy,
    output logic             done_reading_givens
);
    state_e     state_q;
    logic [1:0] cnt_q, addr_q, idx_q;
    row_t       data_q, col_w;
    logic       tr_q, tr_in, rd_valid, cap, last;

    givens_rd_latency_pipe #(.DEPTH(READ_LATENCY)) u_pipe (
        .clk(clk), .rst(rst), .en_i(enb_givens), .valid_o(rd_valid)
    );

    assign cap  = state_q == S_WAIT && rd_valid;
    assign last = cnt_q == 2'd3;

`ifdef GIVENS_TRANSPOSE_EN
    row_t       buf_q [N];
    row_t       buf_n [N];
    logic [1:0] col_sel;
    assign tr_in   = transpose;
    // The first column is built in the same cycle row 3 arrives, so bypass doutb into the buffer view
    assign col_sel = cap ? 2'd0 : cnt_q + 2'd1;
    always_comb begin
        col_w = '0;
        for (int i = 0; i < N; i++) begin
            buf_n[i] = (cap && cnt_q == 2'(i)) ? doutb_givens : buf_q[i];
            col_w[ROW_W-1-ELEM_W*i -: ELEM_W] = get_elem(buf_n[i], col_sel);
        end
    end
    always_ff @(posedge clk) begin
        if (rst) for (int i = 0; i < N; i++) buf_q[i] <= '0;
        else if (cap && tr_q) buf_q[cnt_q] <= doutb_givens;
    end
`else
    assign tr_in = 1'b0;
    assign col_w = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            tr_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (start_read_givens) begin
                    state_q <= S_READ;
                    cnt_q   <= '0;
                    addr_q  <= '0;
                    tr_q    <= tr_in;
                end
                S_READ: state_q <= S_WAIT;
                S_WAIT: if (cap) begin
                    if (!tr_q) begin
                        state_q <= S_PRESENT;
                        data_q  <= doutb_givens;
                        idx_q   <= cnt_q;
                    end else if (last) begin
                        state_q <= S_PRESENT;
                        cnt_q   <= '0;
                        data_q  <= col_w;
                        idx_q   <= '0;
                    end else begin
                        state_q <= S_READ;
                        cnt_q   <= cnt_q + 2'd1;
                        addr_q  <= cnt_q + 2'd1;
                    end
                end
                S_PRESENT: if (vec_ready) begin
                    if (last) state_q <= S_DONE;
                    else if (tr_q) begin
                        cnt_q  <= cnt_q + 2'd1;
                        data_q <= col_w;
                        idx_q  <= cnt_q + 2'd1;
                    end else begin
                        state_q <= S_READ;
                        cnt_q   <= cnt_q + 2'd1;
                        addr_q  <= cnt_q + 2'd1;
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign enb_givens          = state_q == S_READ;
    assign addrb_givens        = addr_q;
    assign vec_data            = data_q;
    assign vec_idx             = idx_q;
    assign vec_valid           = state_q == S_PRESENT;
    assign busy                = state_q != S_IDLE;
    assign done_reading_givens = state_q == S_DONE;
endmodule

// File: tb/tb_givens_matrix_reader.sv
// tb_givens_matrix_reader: two readers (latency 1 and 2) driven in lockstep against a BRAM and matrix model
module tb_givens_matrix_reader;
    logic clk = 0, rst = 1, start = 0, ready = 0, tr = 0;
    logic [1:0] en, vv, bs, dn, stall;
    logic [1:0][1:0] ad, vi, hold_i;
    logic [1:0][31:0] dout, vd, p1, p2, hold_d;
    logic [31:0] mem [4];
    int total = 0, bad = 0, cyc = 0, t0 = 0;
    int n_acc [2], n_en [2], n_done [2], first_v [2], done_rel [2], last_acc [2];
    logic [31:0] got_d [2][8];
    logic [1:0]  got_i [2][8];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk)
        for (int g = 0; g < 2; g++) begin
            if (en[g]) p1[g] <= mem[ad[g]];
            p2[g] <= p1[g];
        end
    assign dout = {p2[1], p1[0]};

    for (genvar g = 0; g < 2; g++) begin : gd
        givens_matrix_reader #(.READ_LATENCY(g + 1)) dut (
            .clk(clk), .rst(rst), .start_read_givens(start),
`ifdef GIVENS_TRANSPOSE_EN
            .transpose(tr),
`endif
            .enb_givens(en[g]), .addrb_givens(ad[g]), .doutb_givens(dout[g]),
            .vec_data(vd[g]), .vec_idx(vi[g]), .vec_valid(vv[g]), .vec_ready(ready),
            .busy(bs[g]), .done_reading_givens(dn[g])
        );
    end

    always @(negedge clk)
        if (!rst)
            for (int g = 0; g < 2; g++) begin
                if (en[g]) n_en[g]++;
                if (dn[g]) begin n_done[g]++; done_rel[g] = cyc - t0; end
                if (vv[g] && first_v[g] < 0) first_v[g] = cyc - t0;
                total++;
                if (vv[g] && dn[g]) begin
                    bad++;
                    $display("FAIL excl L=%0d: valid=%b done=%b, must not both be 1", g + 1, vv[g], dn[g]);
                end
                if (stall[g]) begin
                    total++;
                    if (vv[g] !== 1'b1 || vd[g] !== hold_d[g] || vi[g] !== hold_i[g]) begin
                        bad++;
                        $display("FAIL stall L=%0d: got v=%b d=%h i=%0d need v=1 d=%h i=%0d",
                                 g + 1, vv[g], vd[g], vi[g], hold_d[g], hold_i[g]);
                    end
                end
                if (vv[g] && ready) begin
                    if (n_acc[g] < 8) begin got_d[g][n_acc[g]] = vd[g]; got_i[g][n_acc[g]] = vi[g]; end
                    n_acc[g]++;
                    last_acc[g] = cyc - t0;
                end
                stall[g] = vv[g] && !ready;
                hold_d[g] = vd[g];
                hold_i[g] = vi[g];
            end

    function automatic logic [31:0] exp_vec(bit trv, int k);
        logic [31:0] v = '0;
        if (!trv) return mem[k];
        for (int i = 0; i < 4; i++) v[31-8*i -: 8] = mem[i][31-8*k -: 8];
        return v;
    endfunction

    task automatic clear_stats;
        for (int g = 0; g < 2; g++) begin
            n_acc[g] = 0; n_en[g] = 0; n_done[g] = 0;
            first_v[g] = -1; done_rel[g] = -1; last_acc[g] = -1;
        end
        stall = '0;
    endtask

    task automatic pulse_start(bit trv);
        @(posedge clk); #1;
        clear_stats();
        tr = trv; start = 1; t0 = cyc;
        @(posedge clk); #1;
        start = 0;
    endtask

    task automatic run(int n, int rmode);
        for (int k = 0; k < n; k++) begin
            ready = rmode == 1 ? (((cyc - t0) / 2) % 2 == 1) : 1'b1;
            start = rmode == 2 && ((cyc - t0) inside {2, 5, 9, 13});
            @(posedge clk); #1;
        end
        start = 0;
    endtask

    task automatic test_reset;
        rst = 1; start = 0;
        @(posedge clk); #1;
        for (int g = 0; g < 2; g++) begin
            total++;
            if ({en[g], ad[g], vd[g], vi[g], vv[g], bs[g], dn[g]} !== '0) begin
                bad++;
                $display("FAIL reset L=%0d: en=%b ad=%0d d=%h i=%0d v=%b busy=%b done=%b, all required 0",
                         g + 1, en[g], ad[g], vd[g], vi[g], vv[g], bs[g], dn[g]);
            end
        end
        rst = 0;
        clear_stats();
    endtask

    task automatic test_rows(bit rnd, int rmode, bit trv);
        int l, fv, la, dr;
        if (rnd) for (int i = 0; i < 4; i++) mem[i] = $urandom;
        else begin
            mem[0] = 32'h7F300000; mem[1] = 32'hD07F0000;
            mem[2] = 32'h00007F00; mem[3] = 32'h0000007F;
        end
        ready = 1;
        pulse_start(trv);
        run(70, rmode);
        for (int g = 0; g < 2; g++) begin
            l = g + 1;
            total++;
            if (n_acc[g] != 4) begin bad++; $display("FAIL count L=%0d tr=%0d: got %0d transfers need 4", l, trv, n_acc[g]); end
            for (int k = 0; k < 4 && k < n_acc[g]; k++) begin
                total++;
                if (got_d[g][k] !== exp_vec(trv, k) || got_i[g][k] !== 2'(k)) begin
                    bad++;
                    $display("FAIL vec L=%0d tr=%0d #%0d: got %h idx %0d need %h idx %0d",
                             l, trv, k, got_d[g][k], got_i[g][k], exp_vec(trv, k), k);
                end
            end
            total++;
            if (n_done[g] != 1) begin bad++; $display("FAIL done_cnt L=%0d: got %0d need 1", l, n_done[g]); end
            total++;
            if (n_en[g] != 4) begin bad++; $display("FAIL enb_cnt L=%0d: got %0d need 4", l, n_en[g]); end
            if (rmode != 1) begin
                fv = trv ? 4 * (l + 1) + 1 : 2 + l;
                la = trv ? fv + 3 : 4 * (l + 2);
                dr = trv ? fv + 4 : 4 * (l + 2) + 1;
                total++;
                if (first_v[g] != fv || last_acc[g] != la || done_rel[g] != dr) begin
                    bad++;
                    $display("FAIL timing L=%0d tr=%0d: got first=%0d last=%0d done=%0d need %0d %0d %0d",
                             l, trv, first_v[g], last_acc[g], done_rel[g], fv, la, dr);
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        bit found = 0;
        ready = 1;
        pulse_start(0);
        for (int k = 0; k < 30 && !found; k++) begin
            if (vv[0] && vi[0] == 2'd1) found = 1;
            else begin @(posedge clk); #1; end
        end
        total++;
        if (!found) begin bad++; $display("FAIL reset_mid: row 1 never presented, got 0 need 1"); end
        test_reset();
        test_rows(0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_rows(0, 0, 0);
        test_rows(0, 1, 0);
        test_rows(1, 1, 0);
        test_rows(1, 0, 0);
        test_rows(0, 2, 0);
        test_reset_mid();
`ifdef GIVENS_TRANSPOSE_EN
        test_rows(0, 0, 1);
        test_rows(1, 1, 1);
        test_rows(1, 0, 0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
